// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl: stepped frequency sweep for a DDS tuning word.
// Optional `SWEEP_LOOP_EN adds a Loop input for repeating sweeps.
module freq_sweep_ctrl #(
  parameter int DWELL_W = 24
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Abort,
  input  logic [31:0]        F_start,
  input  logic [31:0]        F_stop,
  input  logic [31:0]        F_step,
  input  logic [DWELL_W-1:0] Dwell,
`ifdef SWEEP_LOOP_EN
  input  logic               Loop,
`endif
  output logic [31:0]        Fword,
  output logic               Busy,
  output logic               Step_tick,
  output logic               Done
);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    DONE
  } state_t;

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  state_t             state_q, state_d;
  logic [31:0]        fword_q, fword_d;
  logic [31:0]        stop_q, stop_d;
  logic [31:0]        step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               up_q, up_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
`ifdef SWEEP_LOOP_EN
  logic [31:0]        start_q, start_d;
`endif

  logic [32:0] sum33;
  logic [32:0] diff33;
  logic [31:0] nxt_fword;

  // Next tuning word: 33-bit step, clamped at the stop word
  always_comb begin
    sum33  = {1'b0, fword_q} + {1'b0, step_q};
    diff33 = {1'b0, fword_q} - {1'b0, step_q};
    if (step_q == 32'd0) begin
      nxt_fword = stop_q;
    end else if (up_q) begin
      if (sum33[32] || (sum33[31:0] > stop_q))
        nxt_fword = stop_q;
      else
        nxt_fword = sum33[31:0];
    end else begin
      if (diff33[32] || (diff33[31:0] < stop_q))
        nxt_fword = stop_q;
      else
        nxt_fword = diff33[31:0];
    end
  end

  // Sweep FSM next-state and datapath
  always_comb begin
    state_d = state_q;
    fword_d = fword_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    up_d    = up_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SWEEP_LOOP_EN
    start_d = start_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start && !Abort) begin
          stop_d  = F_stop;
          step_d  = F_step;
          dwell_d = (Dwell == '0) ? ONE : Dwell;
          up_d    = (F_stop >= F_start);
          fword_d = F_start;
          cnt_d   = ONE;
          state_d = DWELL;
`ifdef SWEEP_LOOP_EN
          start_d = F_start;
`endif
        end
      end
      DWELL: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (cnt_q == dwell_q) begin
          cnt_d = ONE;
          if (fword_q == stop_q) begin
            done_d = 1'b1;
`ifdef SWEEP_LOOP_EN
            if (Loop)
              fword_d = start_q;
            else
              state_d = DONE;
`else
            state_d = DONE;
`endif
          end else begin
            fword_d = nxt_fword;
            tick_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      fword_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SWEEP_LOOP_EN
      start_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      fword_q <= fword_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
`ifdef SWEEP_LOOP_EN
      start_q <= start_d;
`endif
    end
  end

  assign Fword     = fword_q;
  assign Busy      = (state_q == DWELL);
  assign Step_tick = tick_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// tb_freq_sweep_ctrl: directed bench for freq_sweep_ctrl.
// Define SWEEP_LOOP_EN to also cover the looping build.
module tb_freq_sweep_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Abort;
  logic [31:0] F_start;
  logic [31:0] F_stop;
  logic [31:0] F_step;
  logic [23:0] Dwell;
`ifdef SWEEP_LOOP_EN
  logic        Loop;
`endif
  logic [31:0] Fword;
  logic        Busy;
  logic        Step_tick;
  logic        Done;

  int checks = 0;
  int errors = 0;

  freq_sweep_ctrl #(.DWELL_W(24)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Abort     (Abort),
    .F_start   (F_start),
    .F_stop    (F_stop),
    .F_step    (F_step),
    .Dwell     (Dwell),
`ifdef SWEEP_LOOP_EN
    .Loop      (Loop),
`endif
    .Fword     (Fword),
    .Busy      (Busy),
    .Step_tick (Step_tick),
    .Done      (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Start pulse sampled at edge N; returns in cycle N+1
  task automatic start_sweep(input logic [31:0] fs,
                             input logic [31:0] fe,
                             input logic [31:0] st,
                             input logic [23:0] dw);
    F_start = fs;
    F_stop  = fe;
    F_step  = st;
    Dwell   = dw;
    Start   = 1'b1;
    cyc();
    Start   = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Start   = 1'b0;
    Abort   = 1'b0;
    F_start = '0;
    F_stop  = '0;
    F_step  = '0;
    Dwell   = '0;
`ifdef SWEEP_LOOP_EN
    Loop    = 1'b0;
`endif
    repeat (3) cyc();
    checks++;
    if ({Fword, Busy, Step_tick, Done} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state got %h/%b/%b/%b want 0/0/0/0",
               Fword, Busy, Step_tick, Done);
    end
    Reset_n = 1'b1;
    cyc();
  endtask

  // 100..130 step 10 dwell 3; also probes latch isolation
  task automatic check_up_seq(input string tag);
    logic [31:0] ef;
    logic et, eb, ed;
    start_sweep(32'd100, 32'd130, 32'd10, 24'd3);
    for (int c = 1; c <= 14; c++) begin
      ef = (c <= 3) ? 32'd100 : (c <= 6) ? 32'd110 :
           (c <= 9) ? 32'd120 : 32'd130;
      et = (c == 4) || (c == 7) || (c == 10);
      eb = (c <= 12);
      ed = (c == 13);
      checks++;
      if (Fword !== ef) begin
        errors++;
        $display("FAIL %s_fword c%0d got %0d want %0d",
                 tag, c, Fword, ef);
      end
      checks++;
      if (Step_tick !== et) begin
        errors++;
        $display("FAIL %s_tick c%0d got %b want %b",
                 tag, c, Step_tick, et);
      end
      checks++;
      if (Busy !== eb) begin
        errors++;
        $display("FAIL %s_busy c%0d got %b want %b",
                 tag, c, Busy, eb);
      end
      checks++;
      if (Done !== ed) begin
        errors++;
        $display("FAIL %s_done c%0d got %b want %b",
                 tag, c, Done, ed);
      end
      if (c == 2) begin
        F_start = 32'd7;
        F_stop  = 32'd9999;
        F_step  = 32'd1;
        Dwell   = 24'd1;
      end
      Start = (c == 5);
      cyc();
    end
    Start = 1'b0;
  endtask

  task automatic test_up_sweep();
    check_up_seq("up");
  endtask

  task automatic test_clamp_down();
    logic [31:0] e_up[4] = '{32'd0, 32'd10, 32'd20, 32'd25};
    logic [31:0] e_dn[3] = '{32'd50, 32'd35, 32'd20};
    int dones;
    start_sweep(32'd0, 32'd25, 32'd10, 24'd1);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Fword !== e_up[i] || Busy !== 1'b1) begin
        errors++;
        $display("FAIL clamp_fword i%0d got %0d/%b want %0d/1",
                 i, Fword, Busy, e_up[i]);
      end
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      if (Done === 1'b1) dones++;
      if (i == 0) begin
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Fword !== 32'd25) begin
          errors++;
          $display("FAIL clamp_end got %b/%b/%0d want 1/0/25",
                   Done, Busy, Fword);
        end
      end
      cyc();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL clamp_done_count got %0d want 1", dones);
    end
    start_sweep(32'd50, 32'd20, 32'd15, 24'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (Fword !== e_dn[i] || Step_tick !== (i > 0)) begin
        errors++;
        $display("FAIL down_fword i%0d got %0d/%b want %0d",
                 i, Fword, Step_tick, e_dn[i]);
      end
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      if (Done === 1'b1) dones++;
      cyc();
    end
    checks++;
    if (dones != 1 || Fword !== 32'd20 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL down_end got done=%0d f=%0d b=%b want 1/20/0",
               dones, Fword, Busy);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] e[4] = '{32'h0000_000A, 32'h0000_0000,
                          32'h0000_0000, 32'h0000_0000};
    start_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd1);
    checks++;
    if (Fword !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL ovf_first got %h want fffffff0", Fword);
    end
    cyc();
    checks++;
    if (Fword !== 32'hFFFF_FFFF || Step_tick !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clamp got %h/%b want ffffffff/1",
               Fword, Step_tick);
    end
    cyc();
    checks++;
    if (Fword !== 32'hFFFF_FFFF || Done !== 1'b1) begin
      errors++;
      $display("FAIL ovf_done got %h/%b want ffffffff/1",
               Fword, Done);
    end
    cyc();
    start_sweep(32'd10, 32'd0, 32'd20, 24'd1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (Fword !== e[i]) begin
        errors++;
        $display("FAIL udf_fword i%0d got %h want %h",
                 i, Fword, e[i]);
      end
      cyc();
    end
    checks++;
    if (Done !== 1'b1 || Fword !== 32'd0) begin
      errors++;
      $display("FAIL udf_done got %b/%h want 1/0", Done, Fword);
    end
    cyc();
  endtask

  task automatic test_step_zero();
    logic [31:0] e[4] = '{32'd5, 32'd5, 32'd9, 32'd9};
    start_sweep(32'd5, 32'd9, 32'd0, 24'd2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (Fword !== e[i] || Step_tick !== (i == 2)) begin
        errors++;
        $display("FAIL step0 i%0d got %0d/%b want %0d/%b",
                 i, Fword, Step_tick, e[i], (i == 2));
      end
      cyc();
    end
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL step0_done got %b/%b want 1/0", Done, Busy);
    end
    cyc();
  endtask

  task automatic test_abort();
    start_sweep(32'd100, 32'd130, 32'd10, 24'd3);
    repeat (4) cyc();
    Abort = 1'b1;
    cyc();
    Abort = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Fword !== 32'd110) begin
      errors++;
      $display("FAIL abort_stop got %b/%0d want 0/110", Busy, Fword);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (Done !== 1'b0 || Step_tick !== 1'b0 ||
          Busy !== 1'b0 || Fword !== 32'd110) begin
        errors++;
        $display("FAIL abort_hold i%0d got d%b t%b b%b f%0d",
                 i, Done, Step_tick, Busy, Fword);
      end
      cyc();
    end
    F_start = 32'd1;
    F_stop  = 32'd3;
    F_step  = 32'd1;
    Dwell   = 24'd1;
    Start   = 1'b1;
    Abort   = 1'b1;
    cyc();
    Start   = 1'b0;
    Abort   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (Busy !== 1'b0 || Fword !== 32'd110) begin
        errors++;
        $display("FAIL start_abort i%0d got %b/%0d want 0/110",
                 i, Busy, Fword);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    start_sweep(32'd100, 32'd130, 32'd10, 24'd3);
    repeat (4) cyc();
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (Fword !== 32'd0 || Busy !== 1'b0 ||
        Step_tick !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got %0d/%b/%b/%b want 0/0/0/0",
               Fword, Busy, Step_tick, Done);
    end
    cyc();
    cyc();
    Reset_n = 1'b1;
    check_up_seq("rst");
  endtask

`ifdef SWEEP_LOOP_EN
  task automatic test_loop();
    logic [31:0] e[6] = '{32'd0, 32'd0, 32'd10,
                          32'd10, 32'd20, 32'd20};
    Loop = 1'b1;
    start_sweep(32'd0, 32'd20, 32'd10, 24'd2);
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (Fword !== e[i % 6] || Busy !== 1'b1 ||
          Done !== (i == 6 || i == 12)) begin
        errors++;
        $display("FAIL loop i%0d got f%0d b%b d%b want f%0d",
                 i, Fword, Busy, Done, e[i % 6]);
      end
      cyc();
    end
    Abort = 1'b1;
    cyc();
    Abort = 1'b0;
    Loop  = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL loop_abort got %b/%b want 0/0", Busy, Done);
    end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_up_sweep();
    test_clamp_down();
    test_overflow();
    test_step_zero();
    test_abort();
    test_reset_mid();
`ifdef SWEEP_LOOP_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 24, width of the dwell count.
REQ-002 SHALL have port Clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  input  1  single-cycle sweep request.
REQ-005 SHALL have port Abort  input  1  terminate the sweep in progress.
REQ-006 SHALL have port F_start  input  32  first frequency control word.
REQ-007 SHALL have port F_stop  input  32  final frequency control word.
REQ-008 SHALL have port F_step  input  32  unsigned step magnitude.
REQ-009 SHALL have port Dwell  input  DWELL_W  clocks held per frequency; 0 is treated as 1.
REQ-010 SHALL have port Fword  output  32  frequency control word to the DDS phase accumulator.
REQ-011 SHALL have port Busy  output  1  high while sweeping.
REQ-012 SHALL have port Step_tick  output  1  one-cycle pulse on each Fword change after the first.
REQ-013 SHALL have port Done  output  1  one-cycle pulse when a sweep completes normally.

Function
REQ-014 SHALL implement FSM states IDLE, DWELL and DONE.
REQ-015 In IDLE, Start=1 at edge N SHALL latch F_start, F_stop, F_step and Dwell, set Fword=F_start and Busy=1 from cycle N+1, and enter DWELL.
REQ-016 Direction SHALL be fixed at the latch: up if F_stop >= F_start, else down.
REQ-017 Each Fword value, including the first and the last, SHALL be held for exactly max(Dwell,1) cycles.
REQ-018 At dwell end, if Fword != F_stop, Fword SHALL advance by F_step in the latched direction, Step_tick SHALL pulse in the same cycle as the new Fword, and the dwell count SHALL restart.
REQ-019 Advance SHALL use 33-bit arithmetic; a result past F_stop, or a 32-bit overflow or underflow, SHALL clamp to F_stop.
REQ-020 F_step=0 SHALL be treated as a jump to F_stop at the first dwell end.
REQ-021 At dwell end with Fword == F_stop, the FSM SHALL go through DONE: Done=1 and Busy=0 in the same single cycle, then IDLE.
REQ-022 Fword SHALL hold its last value in IDLE and DONE.
REQ-023 Start while Busy=1 SHALL be ignored.
REQ-024 Abort=1 while Busy=1 SHALL force IDLE at the next edge with Busy=0 and Fword held. Done SHALL NOT pulse and Step_tick SHALL NOT pulse.
REQ-025 Abort and Start asserted together in IDLE: Abort SHALL win and no sweep starts.
REQ-026 Latched parameters SHALL NOT be affected by input changes during a sweep.

Reset
REQ-027 Reset_n=0 SHALL asynchronously force IDLE, Fword=0, Busy=0, Step_tick=0, Done=0, clear all latched registers and counters, and abandon any sweep in progress.
REQ-028 The first Start sampled after reset release SHALL be honoured normally.

Configuration
REQ-029 With macro SWEEP_LOOP_EN defined, the block SHALL add an input port Loop (1 bit). When Loop=1 at a sweep's final dwell end, Done SHALL pulse and Fword SHALL reload F_start in that same cycle, with Busy remaining 1 and the sweep repeating until Abort.
REQ-030 Without SWEEP_LOOP_EN, the Loop port and its logic SHALL be absent and every sweep SHALL be one-shot.

Verification
REQ-031 Up sweep: F_start=100, F_stop=130, F_step=10, Dwell=3, Start at N -> Fword 100/110/120/130 at N+1/N+4/N+7/N+10; Step_tick at N+4, N+7, N+10; Done and Busy falling at N+13.
REQ-032 Clamp and down sweep: 0->25 step 10 Dwell=1 -> Fword 0,10,20,25; 50->20 step 15 -> Fword 50,35,20; Done once per sweep.
REQ-033 Overflow: F_start=0xFFFFFFF0, F_stop=0xFFFFFFFF, F_step=0x20 -> Fword 0xFFFFFFF0 then 0xFFFFFFFF, with no wrap to a low value.
REQ-034 Abort at N+5 during the REQ-031 sweep -> Busy=0 at N+6, Fword=110 held, no Done; Start+Abort together in IDLE -> Busy stays 0.
REQ-035 Reset_n low mid-sweep -> Fword=0 and Busy=0 immediately; a Start after release runs the full REQ-031 sequence.
REQ-036 With SWEEP_LOOP_EN and Loop=1, 0->20 step 10 Dwell=2 -> Fword 0,10,20,0,10,... with Done at each reload and Busy constant 1.
